// File: rtl/render_pkg.sv
// render_pkg: shared tile-map geometry, tile code type and named codes for the renderer.
package render_pkg;
  localparam int MAP_COLS = 20;
  localparam int MAP_ROWS = 20;
  localparam int TILE_SHIFT = 4;
  localparam int MAP_PIXELS = 320;
  localparam int MAP_TILES = MAP_COLS * MAP_ROWS;
  typedef logic [4:0] tile_code_t;
  typedef tile_code_t [0:MAP_TILES-1] map_t;
  localparam tile_code_t FLOOR = 5'd0;
  localparam tile_code_t SPAWN = 5'd31;
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: maps a scan position to tile row/col, row-major map index and intra-tile offsets.
module tile_addr_gen
  import render_pkg::*;
(
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  output logic [9-TILE_SHIFT:0] col,
  output logic [9-TILE_SHIFT:0] row,
  output logic [10:0]           idx,
  output logic                  in_map,
  output logic [TILE_SHIFT-1:0] off_x,
  output logic [TILE_SHIFT-1:0] off_y
);
  always_comb begin
    col = x[9:TILE_SHIFT];
    row = y[9:TILE_SHIFT];
    off_x = x[TILE_SHIFT-1:0];
    off_y = y[TILE_SHIFT-1:0];
    // full 10-bit compare so far-off-screen positions never alias back into the map
    in_map = (x < 10'(MAP_PIXELS)) && (y < 10'(MAP_PIXELS));
    idx = in_map ? 11'(row) * 11'(MAP_COLS) + 11'(col) : 11'd0;
  end
endmodule

// File: rtl/tile_render_pipeline.sv
// tile_render_pipeline: 3-stage scan-to-palette-index renderer reading a per-frame tile map snapshot.
module tile_render_pipeline
  import render_pkg::*;
#(
  parameter logic [3:0] BG_INDEX   = 4'd0,
  parameter tile_code_t SPAWN_CODE = SPAWN
) (
  input  logic        Clk,
  input  logic        reset,
  input  map_t        mapData,
  input  logic        frameStart,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blankIn,
  output logic [12:0] romAddr,
  input  logic [3:0]  romData,
  output logic [3:0]  pixelIndex,
  output logic        pixelInMap,
  output logic        pixelValid,
  output logic [9:0]  outX,
  output logic [9:0]  outY
);
  map_t snap;
  logic [9-TILE_SHIFT:0] unused_col, unused_row;
  logic [10:0] a_idx, s1_idx;
  logic a_in, s1_in, s1_valid, s2_in, s2_valid;
  logic [3:0] a_x, a_y, s1_x, s1_y, s2_x, s2_y;
  logic [9:0] s1_dx, s1_dy, s2_dx, s2_dy;
  tile_code_t look, s2_code;
  logic unused_idx_hi;
  tile_addr_gen addr_gen (
    .x(DrawX), .y(DrawY), .col(unused_col), .row(unused_row),
    .idx(a_idx), .in_map(a_in), .off_x(a_x), .off_y(a_y)
  );
  // idx never exceeds 399, so the low 9 bits address the whole map
  assign look = snap[s1_idx[8:0]];
  assign unused_idx_hi = ^s1_idx[10:9];
  assign romAddr = {s2_code, s2_y, s2_x};
  always_ff @(posedge Clk) begin
    if (reset) begin
      snap <= '0;
      s1_idx <= '0;
      s1_x <= '0;
      s1_y <= '0;
      s1_in <= 1'b0;
      s1_valid <= 1'b0;
      s1_dx <= '0;
      s1_dy <= '0;
      s2_code <= FLOOR;
      s2_x <= '0;
      s2_y <= '0;
      s2_in <= 1'b0;
      s2_valid <= 1'b0;
      s2_dx <= '0;
      s2_dy <= '0;
      pixelIndex <= BG_INDEX;
      pixelInMap <= 1'b0;
      pixelValid <= 1'b0;
      outX <= '0;
      outY <= '0;
    end else begin
      if (frameStart) snap <= mapData;
      s1_idx <= a_idx;
      s1_x <= a_x;
      s1_y <= a_y;
      s1_in <= a_in;
      s1_valid <= blankIn;
      s1_dx <= DrawX;
      s1_dy <= DrawY;
      s2_code <= (!s1_in || look == SPAWN_CODE) ? FLOOR : look;
      s2_x <= s1_x;
      s2_y <= s1_y;
      s2_in <= s1_in;
      s2_valid <= s1_valid;
      s2_dx <= s1_dx;
      s2_dy <= s1_dy;
      pixelIndex <= s2_in ? romData : BG_INDEX;
      pixelInMap <= s2_in;
      pixelValid <= s2_valid;
      outX <= s2_dx;
      outY <= s2_dy;
    end
  end
endmodule

// File: tb/tb_tile_render_pipeline.sv
// tb_tile_render_pipeline: directed stimulus with a due-cycle scoreboard checked by an independent monitor.
module tb_tile_render_pipeline;
  import render_pkg::*;
  logic Clk = 1'b0, reset = 1'b1, frameStart = 1'b0, blankIn = 1'b0;
  map_t mapData = '0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [12:0] romAddr;
  logic [3:0] romData, pixelIndex;
  logic pixelInMap, pixelValid;
  logic [9:0] outX, outY;
  tile_code_t snap_m [MAP_TILES];
  int cyc = 0, checks = 0, errors = 0;
  logic [12:0] prev_addr = '0;
  typedef struct {
    int due;
    logic [12:0] addr;
    bit chk_addr;
    logic [3:0] pix;
    bit inm;
    bit val;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  tile_render_pipeline dut (
    .Clk(Clk), .reset(reset), .mapData(mapData), .frameStart(frameStart),
    .DrawX(DrawX), .DrawY(DrawY), .blankIn(blankIn), .romAddr(romAddr),
    .romData(romData), .pixelIndex(pixelIndex), .pixelInMap(pixelInMap),
    .pixelValid(pixelValid), .outX(outX), .outY(outY)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  function automatic logic [3:0] rom_fn(input logic [12:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ {3'b0, a[12]} ^ 4'h5;
  endfunction
  assign romData = rom_fn(romAddr);
  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.chk_addr) chk("romAddr", prev_addr, mon_e.addr);
      chk("pixelIndex", 13'(pixelIndex), 13'(mon_e.pix));
      chk("pixelInMap", 13'(pixelInMap), 13'(mon_e.inm));
      chk("pixelValid", 13'(pixelValid), 13'(mon_e.val));
      chk("outX", 13'(outX), 13'(mon_e.x));
      chk("outY", 13'(outY), 13'(mon_e.y));
    end
    prev_addr = romAddr;
  end
  // code < 0 takes the tile code from the snapshot model, otherwise it is the hand-computed code
  task automatic drive(input int x, input int y, input bit blank, input bit fs, input bit rst, input int code);
    logic [9:0] xv, yv;
    logic [12:0] a;
    bit inm;
    tile_code_t c;
    @(negedge Clk);
    xv = 10'(x);
    yv = 10'(y);
    DrawX = xv;
    DrawY = yv;
    blankIn = blank;
    frameStart = fs;
    reset = rst;
    if (rst) begin
      foreach (snap_m[i]) snap_m[i] = '0;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      for (int k = 1; k <= 3; k++)
        q.push_back('{due: cyc + k, addr: '0, chk_addr: k > 1, pix: 4'd0, inm: 1'b0, val: 1'b0, x: '0, y: '0});
      return;
    end
    if (fs) foreach (snap_m[i]) snap_m[i] = mapData[i];
    inm = (x < 320) && (y < 320);
    c = inm ? snap_m[(y / 16) * 20 + x / 16] : 5'd0;
    if (c == 5'd31) c = 5'd0;
    if (code >= 0) c = 5'(code);
    a = {c, yv[3:0], xv[3:0]};
    q.push_back('{due: cyc + 3, addr: a, chk_addr: 1'b1, pix: inm ? rom_fn(a) : 4'd0,
                  inm: inm, val: blank, x: xv, y: yv});
  endtask
  initial begin
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    foreach (mapData[i]) mapData[i] = 5'd1;
    drive(400, 400, 0, 1, 0, 0);
    drive(17, 33, 1, 0, 0, 1);
    drive(320, 5, 1, 0, 0, 0);
    drive(0, 320, 1, 0, 0, 0);
    drive(1023, 1023, 1, 0, 0, 0);
    drive(319, 320, 1, 0, 0, 0);
    mapData[399] = 5'd7;
    mapData[0] = 5'd31;
    drive(400, 400, 0, 1, 0, 0);
    drive(319, 319, 1, 0, 0, 7);
    drive(0, 0, 1, 0, 0, 0);
    drive(15, 15, 1, 0, 0, 0);
    drive(16, 0, 1, 0, 0, 1);
    mapData[21] = 5'd3;
    drive(400, 400, 0, 1, 0, 0);
    drive(16, 16, 1, 0, 0, 3);
    mapData[21] = 5'd4;
    drive(16, 16, 1, 0, 0, 3);
    drive(31, 31, 1, 0, 0, 3);
    // this pixel's tile lookup lands in the frameStart cycle below, so it must still see 3
    drive(16, 16, 1, 0, 0, 3);
    drive(400, 400, 0, 1, 0, 0);
    drive(16, 16, 1, 0, 0, 4);
    foreach (mapData[i]) mapData[i] = 5'(i % 32);
    drive(400, 400, 0, 1, 0, 0);
    for (int x = 0; x < 640; x++) drive(x, 50, (x % 7) != 3, 0, 0, -1);
    mapData[0] = 5'd9;
    drive(400, 400, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 9);
    drive(5, 5, 1, 0, 0, 9);
    drive(100, 3, 1, 0, 0, -1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 2, 1, 0, 0, 0);
    drive(400, 400, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 9);
    drive(400, 400, 0, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(400, 400, 0, 0, 0, 0);
    repeat (6) @(negedge Clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected pixels never checked, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
